// File: rtl/xor_cipher_pkg.sv
// Shared types, default constants and the unrolled Galois LFSR step used by
// the multi-channel XOR stream cipher.
package xor_cipher_pkg;

  // Controller states: LOAD seeds the keystreams, RUN ciphers beats, and CFG
  // shifts a new key in over the serial chain.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_CFG  = 2'd2
  } state_t;

  localparam logic [31:0] TAPS_DEFAULT    = 32'h8020_0003;
  localparam logic [31:0] KEY_RST_DEFAULT = 32'h0000_0000;

  // Widest LFSR the step helper supports. Narrower LFSRs are zero-extended.
  // Because the upper bits of both the state and the taps are zero, those
  // bits stay zero after a right shift.
  localparam int MAX_M = 64;

  typedef struct packed {
    logic [MAX_M-1:0] next_state;
    logic [MAX_M-1:0] ks;
  } lfsr_step_t;

  // Advance a right-shifting Galois LFSR by w steps. Bit i of ks is the
  // output bit s[0] of step i. next_state is the state after all w steps.
  function automatic lfsr_step_t lfsr_step_w(input logic [MAX_M-1:0] state,
                                             input logic [MAX_M-1:0] taps,
                                             input int               w);
    lfsr_step_t       r;
    logic [MAX_M-1:0] s;
    logic             b;
    s    = state;
    r.ks = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (i < w) begin
        b       = s[0];
        r.ks[i] = b;
        s       = (s >> 1) ^ (b ? taps : '0);
      end
    end
    r.next_state = s;
    return r;
  endfunction

endpackage

// File: rtl/xor_stream_cipher_mc_if.sv
// Per-channel streaming bus of the multi-channel XOR cipher.
//
// Handshake: each channel c has its own valid/ready pair on both sides. A beat
// transfers on a rising clk edge exactly when valid[c] and ready[c] are both
// high. Once a producer raises valid, it holds both valid and data stable
// until that transfer happens. The ready signal may depend combinationally on
// the consumer's own state. Channels never wait on one another.
interface xor_stream_cipher_mc_if #(
  parameter int N = 2,
  parameter int W = 8
);
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready;

  // Traffic source/sink around the cipher.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The cipher itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xor_cipher_lane.sv
// One cipher channel. It holds the channel's keystream LFSR, XORs each
// accepted beat with the next W keystream bits, and keeps a single registered
// output slot with valid/ready flow control.
module xor_cipher_lane
  import xor_cipher_pkg::*;
#(
  parameter int          M    = 32,
  parameter int          W    = 8,
  parameter logic [M-1:0] TAPS = M'(TAPS_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,       // reseed the LFSR from seed this cycle
  input  logic         run_en,     // controller allows new beats this cycle
  input  logic         bypass,     // pass accepted beats through unciphered
  input  logic [M-1:0] seed,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  lfsr_step_t   step;
  logic [M-1:0] lfsr;
  logic         accept;
  logic         unused_step;

  assign step        = lfsr_step_w(MAX_M'(lfsr), MAX_M'(TAPS), W);
  assign unused_step = ^step;

  // The slot can take a beat when it is empty or is being emptied this cycle.
  assign in_ready = run_en & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // The keystream register moves only on a reseed or on a ciphered beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= seed;
    end else if (accept && !bypass) begin
      lfsr <= step.next_state[M-1:0];
    end
  end

  // Output slot: it fills on accept, drains on out_ready, and otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= bypass ? in_data : (in_data ^ step.ks[W-1:0]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xor_stream_cipher_mc.sv
// Multi-channel XOR stream cipher top.
//
// A single M-bit key is shifted in MSB-first over cfg_en/cfg_i and appears
// daisy-chained on cfg_o. Each channel c seeds its own Galois LFSR from
// key ^ (c+1), where an all-zero seed is replaced by 1. Encrypt and decrypt
// are the same operation.
//
// Optional build macro XOR_CIPHER_BYPASS_EN adds a 'bypass' input. While
// bypass is high, accepted beats pass through unciphered and the LFSRs hold.
module xor_stream_cipher_mc
  import xor_cipher_pkg::*;
#(
  parameter int           M       = 32,
  parameter int           W       = 8,
  parameter int           N       = 2,
  parameter logic [M-1:0] TAPS    = M'(TAPS_DEFAULT),
  parameter logic [M-1:0] KEY_RST = M'(KEY_RST_DEFAULT),
  parameter int           HB_DIV  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic                  cfg_i,
  output logic                  cfg_o,
  input  logic                  sync,
`ifdef XOR_CIPHER_BYPASS_EN
  input  logic                  bypass,
`endif
  xor_stream_cipher_mc_if.slave bus,
  output logic                  busy,
  output logic [2:0]            heartbeat,
  output state_t                fsm_state
);

  state_t            state;
  logic [M-1:0]      key;
  logic [HB_DIV+2:0] hb_cnt;
  logic              load;
  logic              run_en;
  logic              bypass_int;
  logic [N-1:0]      in_ready_v;
  logic [N-1:0]      out_valid_v;
  logic [N*W-1:0]    out_data_v;

`ifdef XOR_CIPHER_BYPASS_EN
  assign bypass_int = bypass;
`else
  assign bypass_int = 1'b0;
`endif

  // Controller FSM plus key shift register. A cfg_en cycle shifts the key in
  // whatever state the controller is in, so N cfg_en cycles load N key bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      key   <= KEY_RST;
    end else begin
      if (cfg_en) begin
        key <= {key[M-2:0], cfg_i};
      end
      case (state)
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  if (cfg_en) state <= ST_CFG;
        ST_CFG:  if (!cfg_en) state <= ST_LOAD;
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Free-running heartbeat counter. Its top three bits are exported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  // LFSRs are reseeded in LOAD and on a sync pulse in RUN. cfg_en outranks
  // sync, and no channel accepts a beat during a cfg_en or sync cycle.
  assign load      = (state == ST_LOAD) | ((state == ST_RUN) & sync & ~cfg_en);
  assign run_en    = (state == ST_RUN) & ~cfg_en & ~sync;
  assign busy      = (state == ST_LOAD) | (state == ST_CFG);
  assign cfg_o     = key[M-1];
  assign heartbeat = hb_cnt[HB_DIV+2:HB_DIV];
  assign fsm_state = state;

  for (genvar c = 0; c < N; c++) begin : g_lane
    logic [M-1:0] seed_raw;
    logic [M-1:0] seed;

    assign seed_raw = key ^ M'(c + 1);
    assign seed     = (seed_raw == '0) ? M'(1) : seed_raw;

    xor_cipher_lane #(
      .M   (M),
      .W   (W),
      .TAPS(TAPS)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .run_en   (run_en),
      .bypass   (bypass_int),
      .seed     (seed),
      .in_valid (bus.in_valid[c]),
      .in_data  (bus.in_data[c*W +: W]),
      .in_ready (in_ready_v[c]),
      .out_valid(out_valid_v[c]),
      .out_data (out_data_v[c*W +: W]),
      .out_ready(bus.out_ready[c])
    );
  end

  assign bus.in_ready  = in_ready_v;
  assign bus.out_valid = out_valid_v;
  assign bus.out_data  = out_data_v;

endmodule

// File: tb/tb_xor_stream_cipher_mc.sv
// Bench for xor_stream_cipher_mc: directed stimulus, a cycle-level reference
// model checked on every falling edge, and literal expectations.
module tb_xor_stream_cipher_mc;
  import xor_cipher_pkg::*;

  localparam int          N    = 2;
  localparam int          W    = 8;
  localparam int          M    = 32;
  localparam int          HB   = 3;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic   clk = 1'b0;
  logic   rst_n, cfg_en, cfg_i, sync, bypass;
  logic   cfg_o, busy;
  logic [2:0] heartbeat;
  state_t fsm_state;

  xor_stream_cipher_mc_if #(.N(N), .W(W)) bus();

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ct_q[$];

  // Reference model state
  state_t       m_mode;
  logic [31:0]  m_key;
  logic [31:0]  m_lfsr[N];
  logic         m_ov[N];
  logic [7:0]   m_od[N];
  int           m_hb;
  bit           m_live = 1'b0;

  xor_stream_cipher_mc #(
    .M(M), .W(W), .N(N), .TAPS(TAPS), .KEY_RST(32'h0), .HB_DIV(HB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (cfg_o),
    .sync     (sync),
`ifdef XOR_CIPHER_BYPASS_EN
    .bypass   (bypass),
`endif
    .bus      (bus),
    .busy     (busy),
    .heartbeat(heartbeat),
    .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Eight keystream bits from state s. Bit i is s[0] at step i.
  task automatic ks_gen(input logic [31:0] s, output logic [7:0] ks, output logic [31:0] ns);
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i] = s[0];
      if (s[0]) s = (s >> 1) ^ TAPS;
      else      s = s >> 1;
    end
    ns = s;
  endtask

  function automatic logic [31:0] seed_of(input logic [31:0] key, input int c);
    logic [31:0] s;
    s = key ^ 32'(c + 1);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check DUT against the model, then advance the model
  initial begin : compare_p
    logic [N-1:0] rdy;
    logic [7:0]   ks;
    logic [31:0]  ns;
    logic         reload;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        rdy[c] = (m_mode == ST_RUN) && !cfg_en && !sync && (!m_ov[c] || bus.out_ready[c]);
      if (m_live) begin
        check("busy", busy, m_mode != ST_RUN);
        check("fsm_state", fsm_state, m_mode);
        check("cfg_o", cfg_o, m_key[31]);
        check("heartbeat", heartbeat, m_hb[5:3]);
        for (int c = 0; c < N; c++) begin
          check($sformatf("out_valid[%0d]", c), bus.out_valid[c], m_ov[c]);
          check($sformatf("out_data[%0d]", c), bus.out_data[c*W +: W], m_od[c]);
          check($sformatf("in_ready[%0d]", c), bus.in_ready[c], rdy[c]);
        end
      end
      if (!rst_n) begin
        m_mode = ST_LOAD;
        m_key  = 32'h0;
        m_hb   = 0;
        for (int c = 0; c < N; c++) begin
          m_lfsr[c] = 32'h0;
          m_ov[c]   = 1'b0;
          m_od[c]   = 8'h00;
        end
        m_live = 1'b1;
      end else if (m_live) begin
        reload = (m_mode == ST_LOAD) || (m_mode == ST_RUN && sync && !cfg_en);
        for (int c = 0; c < N; c++) begin
          if (rdy[c] && bus.in_valid[c]) begin
            ks_gen(m_lfsr[c], ks, ns);
            m_od[c] = bus.in_data[c*W +: W] ^ (bypass ? 8'h00 : ks);
            m_ov[c] = 1'b1;
            if (!bypass) m_lfsr[c] = ns;
          end else if (bus.out_ready[c]) begin
            m_ov[c] = 1'b0;
          end
          if (reload) m_lfsr[c] = seed_of(m_key, c);
        end
        if (cfg_en) m_key = {m_key[30:0], cfg_i};
        case (m_mode)
          ST_LOAD: m_mode = ST_RUN;
          ST_RUN:  if (cfg_en) m_mode = ST_CFG;
          default: if (!cfg_en) m_mode = ST_LOAD;
        endcase
        m_hb = (m_hb + 1) % 64;
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    logic [7:0]  ks;
    logic [31:0] ns, ns2;
    logic [31:0] new_key;

    // Pin the model against hand-computed keystream values
    ks_gen(32'h1, ks, ns);
    check("pin_ks_seed1", ks, 8'hDB);
    check("pin_ns_seed1", ns, 32'hDB36_C002);
    ks_gen(ns, ks, ns2);
    check("pin_ks_beat2", ks, 8'hB6);
    ks_gen(seed_of(32'h0, 1), ks, ns);
    check("pin_ks_ch1", ks, 8'hB6);
    check("pin_seed_zero", seed_of(32'h1, 0), 32'h1);

    rst_n = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; sync = 1'b0; bypass = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = '0;
    repeat (3) step();
    check("rst_out_valid", bus.out_valid, 2'b00);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_busy", busy, 1'b1);
    check("rst_heartbeat", heartbeat, 3'd0);
    check("rst_cfg_o", cfg_o, 1'b0);

    // First beat after reset, key 0: ch0 -> 0xDB, ch1 -> 0xB6
    rst_n = 1'b1;
    step(); step();
    bus.out_ready = 2'b11; bus.in_valid = 2'b11; bus.in_data = 16'h0000;
    step();
    check("first_valid", bus.out_valid, 2'b11);
    check("first_ch0", bus.out_data[7:0], 8'hDB);
    check("first_ch1", bus.out_data[15:8], 8'hB6);
    bus.in_valid = 2'b01;
    step();
    check("second_ch0", bus.out_data[7:0], 8'hB6);
    bus.in_valid = 2'b00;
    step();

    // sync with a held word on ch0
    bus.out_ready = 2'b10; bus.in_valid = 2'b01; bus.in_data[7:0] = 8'h77;
    step();
    bus.in_valid = 2'b00;
    step();
    sync = 1'b1;
    #1;
    check("sync_in_ready", bus.in_ready, 2'b00);
    step();
    sync = 1'b0;
    check("sync_held_valid", bus.out_valid[0], 1'b1);
    bus.out_ready = 2'b11; bus.in_valid = 2'b01; bus.in_data[7:0] = 8'h00;
    step();
    check("post_sync_ch0", bus.out_data[7:0], 8'hDB);
    bus.in_valid = 2'b00;
    step();

    // Shift key 0xA5A5A5A5 MSB-first
    new_key = 32'hA5A5_A5A5;
    for (int i = 0; i < 32; i++) begin
      cfg_en = 1'b1; cfg_i = new_key[31-i];
      step();
      check("cfg_busy", busy, 1'b1);
      check("cfg_in_ready", bus.in_ready, 2'b00);
    end
    check("cfg_o_after_shift", cfg_o, 1'b1);
    cfg_en = 1'b0; cfg_i = 1'b0;
    step();
    check("load_busy", busy, 1'b1);
    check("load_state", fsm_state, ST_LOAD);
    step();
    check("run_in_ready", bus.in_ready, 2'b11);
    check("run_busy", busy, 1'b0);

    // Loopback on ch0
    bus.in_valid = 2'b01;
    for (int i = 0; i < 16; i++) begin
      bus.in_data[7:0] = 8'(i);
      step();
      ct_q.push_back(bus.out_data[7:0]);
    end
    bus.in_valid = 2'b00;
    sync = 1'b1;
    step();
    sync = 1'b0;
    bus.in_valid = 2'b01;
    for (int i = 0; i < 16; i++) begin
      bus.in_data[7:0] = ct_q.pop_front();
      exp_q.push_back(8'(i));
      step();
      check("loopback", bus.out_data[7:0], exp_q.pop_front());
    end
    bus.in_valid = 2'b00;
    step();

    // ch1 back-pressured while ch0 streams
    bus.out_ready = 2'b01; bus.in_valid = 2'b10; bus.in_data[15:8] = 8'h55;
    step();
    bus.in_data[15:8] = 8'h66;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 2'b11;
      bus.in_data[7:0] = 8'(8'h20 + i);
      step();
      check("bp_ch1_ready", bus.in_ready[1], 1'b0);
      check("bp_ch1_valid", bus.out_valid[1], 1'b1);
      check("bp_ch0_ready", bus.in_ready[0], 1'b1);
    end
    bus.in_valid = 2'b00; bus.out_ready = 2'b11;
    step(); step();

    // Reset mid-stream
    bus.in_valid = 2'b01; bus.in_data[7:0] = 8'h5A;
    step(); step();
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", bus.out_valid, 2'b00);
    check("mid_rst_data", bus.out_data, 16'h0000);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_state", fsm_state, ST_LOAD);
    check("mid_rst_cfg_o", cfg_o, 1'b0);
    rst_n = 1'b1; bus.in_valid = 2'b00;
    step(); step();

`ifdef XOR_CIPHER_BYPASS_EN
    bypass = 1'b1; bus.in_valid = 2'b01; bus.in_data[7:0] = 8'h3C;
    step();
    check("bypass_ch0", bus.out_data[7:0], 8'h3C);
    bypass = 1'b0;
`endif
    bus.in_valid = 2'b01; bus.in_data[7:0] = 8'h00;
    step();
    check("post_rst_ch0", bus.out_data[7:0], 8'hDB);
    bus.in_valid = 2'b00;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
